out_channel_reader: RTL and testbench
=====================================

Name: out_channel_reader

Overview:
- Consumer end of the program output channel.
- The executing program pushes one word per `out` instruction. This block buffers those words in an NOut-deep ring and streams them in order to an external consumer over a valid/ready handshake.
- Tracks the program's `finished` indication and reports when every emitted word has been consumed.
- Sits between the generated program core and the test/host harness.

Parameters:
- MemoryElementWidth, 12, width of each channel word.
- NOut, 3, ring depth in words (≥1, need not be a power of two).
- CountWidth, $clog2(NOut+1), width of the occupancy counter.

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clock.
- outWrite  input  1  program pushes outData this cycle.
- outData  input  MemoryElementWidth  word written by the program.
- finished  input  1  program has finished; level, may stay high.
- full  output  1  ring holds NOut words.
- readValid  output  1  readData holds a valid word.
- readData  output  MemoryElementWidth  oldest unconsumed word.
- readReady  input  1  consumer accepts readData this cycle.
- count  output  CountWidth  current occupancy, 0..NOut.
- overflow  output  1  sticky; a write was dropped because the ring was full.
- lateWrite  output  1  sticky; outWrite was seen after finished was latched.
- drained  output  1  finished latched and ring empty.

Behaviour:
- Reset (reset==0 at posedge):
  - writePos, readPos and count become 0; state becomes STREAM.
  - full, readValid, overflow, lateWrite and drained become 0.
  - readData is don't-care while readValid==0.
  - Ring contents are not cleared.
  - Reset mid-stream discards all buffered words.
- Write: outWrite && (!full || readFire) stores outData at writePos. writePos becomes (writePos+1) mod NOut, wrapping NOut-1 to 0.
- readFire = readValid && readReady. It advances readPos mod NOut.
- count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous write and read, including when full.
- Write while full with no readFire: word dropped, writePos unchanged, overflow set to 1 until reset.
- readValid = (count != 0); readData = ring[readPos]. Both are driven from registered state.
  - Write-to-readValid latency: 1 cycle. A word written at edge N is visible after edge N.
  - A write into an empty ring is never visible in the same cycle.
- Handshake rules:
  - readData and readValid are stable while readValid && !readReady.
  - readReady with readValid==0 has no effect.
- full = (count == NOut).
- State machine:
  - STREAM: normal operation. finished==1 at posedge moves to DRAIN, or to DONE if count==0 after that edge's update.
  - DRAIN: writes are still accepted; every outWrite sets lateWrite. Moves to DONE at the edge where count becomes 0.
  - DONE: drained=1. outWrite sets lateWrite and is otherwise handled as in DRAIN. A stored word returns the state to DRAIN and clears drained.
  - finished is only latched. Deasserting it does not leave DRAIN or DONE; only reset does.
- NOut==1: full and readValid are equivalent. Simultaneous write and read still passes one word per cycle.

Test Plan:
- Program order, NOut=3:
  - Stimulus: reset low for 2 cycles; write 1, 2, 3 on consecutive cycles with readReady=0.
  - Response: count=3, full=1, readData=1; then readReady=1 yields 1, 2, 3 on consecutive cycles; count=0.
- Overflow:
  - Stimulus: ring full with 1, 2, 3; write 4 with readReady=0.
  - Response: overflow=1, count=3; subsequent reads yield 1, 2, 3 only.
- Full pass-through:
  - Stimulus: ring full; write 7 with readReady=1 in the same cycle.
  - Response: 1 consumed, 7 stored, count stays 3, overflow=0.
- Wrap-around:
  - Stimulus: 10 words 1..10 with readReady=1 and no backpressure.
  - Response: output sequence 1..10 with write pointer wrapping 3 times, count ≤1 throughout.
- Finish and drain:
  - Stimulus: write 1, 2, 3, raise finished, read all.
  - Response: drained rises the cycle count reaches 0; a later write of 5 gives lateWrite=1, drained=0, readData=5.
- Reset mid-operation:
  - Stimulus: two words buffered and finished latched; reset low for 1 cycle.
  - Response: count=0, readValid=0, drained=0, overflow=0, lateWrite=0, state STREAM.

Source files
------------

// File: rtl/out_channel_reader.sv
// out_channel_reader: buffers program output words in a ring and streams them to a valid/ready consumer
module out_channel_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 3,
  parameter int CountWidth = $clog2(NOut + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          outWrite,
  input  logic [MemoryElementWidth-1:0] outData,
  input  logic                          finished,
  output logic                          full,
  output logic                          readValid,
  output logic [MemoryElementWidth-1:0] readData,
  input  logic                          readReady,
  output logic [CountWidth-1:0]         count,
  output logic                          overflow,
  output logic                          lateWrite,
  output logic                          drained
);
  localparam int PW = NOut > 1 ? $clog2(NOut) : 1;
  localparam logic [PW-1:0] last = PW'(NOut - 1);
  localparam logic [CountWidth-1:0] cmax = CountWidth'(NOut);
  typedef enum logic [1:0] {STREAM, DRAIN, DONE} state_t;
  state_t state, state_next;
  logic [MemoryElementWidth-1:0] ring [NOut];
  logic [PW-1:0] write_pos, read_pos;
  logic read_fire, wr_en;
  logic [CountWidth-1:0] count_next;
  assign full = count == cmax;
  assign readValid = count != '0;
  assign readData = ring[read_pos];
  assign drained = state == DONE;
  assign read_fire = readValid && readReady;
  assign wr_en = outWrite && (!full || read_fire);
  assign count_next = count + CountWidth'(wr_en) - CountWidth'(read_fire);
  // Once finished is latched, DRAIN/DONE simply track whether the ring will be empty
  always_comb begin
    state_next = state;
    if (state != STREAM || finished) state_next = count_next == '0 ? DONE : DRAIN;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      write_pos <= '0;
      read_pos  <= '0;
      count     <= '0;
      state     <= STREAM;
      overflow  <= 1'b0;
      lateWrite <= 1'b0;
    end else begin
      if (wr_en) write_pos <= write_pos == last ? '0 : write_pos + 1'b1;
      if (read_fire) read_pos <= read_pos == last ? '0 : read_pos + 1'b1;
      count <= count_next;
      state <= state_next;
      if (outWrite && full && !read_fire) overflow <= 1'b1;
      if (outWrite && state != STREAM) lateWrite <= 1'b1;
    end
  end
  always_ff @(posedge clock) if (wr_en) ring[write_pos] <= outData;
endmodule

// File: tb/tb_out_channel_reader.sv
// tb_out_channel_reader: directed vector table plus randomized run against a queue-based model
module tb_out_channel_reader;
  localparam int W = 12;
  localparam int N = 3;
  localparam int CW = $clog2(N + 1);
  logic clock = 0, reset = 0, outWrite = 0, finished = 0, readReady = 0;
  logic [W-1:0] outData = '0;
  logic full, readValid, overflow, lateWrite, drained;
  logic [W-1:0] readData;
  logic [CW-1:0] count;
  int errors = 0, checks = 0;
  out_channel_reader #(.MemoryElementWidth(W), .NOut(N)) dut (
    .clock(clock), .reset(reset), .outWrite(outWrite), .outData(outData),
    .finished(finished), .full(full), .readValid(readValid), .readData(readData),
    .readReady(readReady), .count(count), .overflow(overflow),
    .lateWrite(lateWrite), .drained(drained)
  );
  always #5 clock = ~clock;
  typedef struct {
    bit rst_n, w, f, r;
    int d;
    int c, v, rd, ov, lw, dr;
  } vec_t;
  vec_t vecs[$];
  int mq[$];
  bit mfin, mover, mlate;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(bit rst_n, bit w, int d, bit f, bit r);
    bit fire, isfull;
    reset = rst_n; outWrite = w; outData = W'(d); finished = f; readReady = r;
    if (!rst_n) begin
      mq.delete(); mfin = 0; mover = 0; mlate = 0;
    end else begin
      fire = mq.size() != 0 && r;
      isfull = mq.size() == N;
      if (w && mfin) mlate = 1;
      if (w && isfull && !fire) mover = 1;
      if (fire) void'(mq.pop_front());
      if (w && (!isfull || fire)) mq.push_back(d);
      if (f) mfin = 1;
    end
    @(posedge clock);
    #1;
  endtask
  task automatic check_model(string tag);
    chk({tag, " count"}, int'(count), mq.size());
    chk({tag, " valid"}, int'(readValid), int'(mq.size() != 0));
    chk({tag, " full"}, int'(full), int'(mq.size() == N));
    if (mq.size() != 0) chk({tag, " data"}, int'(readData), mq[0]);
    chk({tag, " overflow"}, int'(overflow), int'(mover));
    chk({tag, " late"}, int'(lateWrite), int'(mlate));
    chk({tag, " drained"}, int'(drained), int'(mfin && mq.size() == 0));
  endtask
  function automatic void add(bit rst_n, bit w, int d, bit f, bit r, int c, int v, int rd, int ov, int lw, int dr);
    vec_t x;
    x.rst_n = rst_n; x.w = w; x.d = d; x.f = f; x.r = r;
    x.c = c; x.v = v; x.rd = rd; x.ov = ov; x.lw = lw; x.dr = dr;
    vecs.push_back(x);
  endfunction
  initial begin
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,1,0,0, 1,1,1,0,0,0);
    add(1,1,2,0,0, 2,1,1,0,0,0);
    add(1,1,3,0,0, 3,1,1,0,0,0);
    add(1,1,4,0,0, 3,1,1,1,0,0);
    add(1,0,0,0,1, 2,1,2,1,0,0);
    add(1,0,0,0,1, 1,1,3,1,0,0);
    add(1,0,0,0,1, 0,0,0,1,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,1,0,0, 1,1,1,0,0,0);
    add(1,1,2,0,0, 2,1,1,0,0,0);
    add(1,1,3,0,0, 3,1,1,0,0,0);
    add(1,1,7,0,1, 3,1,2,0,0,0);
    add(1,0,0,0,1, 2,1,3,0,0,0);
    add(1,0,0,0,1, 1,1,7,0,0,0);
    add(1,0,0,0,1, 0,0,0,0,0,0);
    add(1,1,1,0,1, 1,1,1,0,0,0);
    for (int i = 2; i <= 10; i++) add(1,1,i,0,1, 1,1,i,0,0,0);
    add(1,0,0,0,1, 0,0,0,0,0,0);
    add(1,1,1,0,0, 1,1,1,0,0,0);
    add(1,1,2,0,0, 2,1,1,0,0,0);
    add(1,1,3,0,0, 3,1,1,0,0,0);
    add(1,0,0,1,0, 3,1,1,0,0,0);
    add(1,0,0,0,1, 2,1,2,0,0,0);
    add(1,0,0,0,1, 1,1,3,0,0,0);
    add(1,0,0,0,1, 0,0,0,0,0,1);
    add(1,0,0,0,0, 0,0,0,0,0,1);
    add(1,1,5,0,0, 1,1,5,0,1,0);
    add(1,1,9,0,0, 2,1,5,0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,6,0,0, 1,1,6,0,0,0);
    add(1,0,0,1,1, 0,0,0,0,0,1);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].w, vecs[i].d, vecs[i].f, vecs[i].r);
      chk($sformatf("vec%0d count", i), int'(count), vecs[i].c);
      chk($sformatf("vec%0d valid", i), int'(readValid), vecs[i].v);
      chk($sformatf("vec%0d full", i), int'(full), int'(vecs[i].c == N));
      if (vecs[i].v != 0) chk($sformatf("vec%0d data", i), int'(readData), vecs[i].rd);
      chk($sformatf("vec%0d overflow", i), int'(overflow), vecs[i].ov);
      chk($sformatf("vec%0d late", i), int'(lateWrite), vecs[i].lw);
      chk($sformatf("vec%0d drained", i), int'(drained), vecs[i].dr);
    end
    step(0, 0, 0, 0, 0);
    check_model("rnd reset");
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
      check_model($sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
